// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode/issue stage and its neighbours.
// Carries the upstream instruction channel, the downstream ALU channel and flush.
// slave = issue stage view, master = driver/consumer view (used by the bench).
//
// Ports: flush; in_valid/in_ready + in_inst/in_pc/in_rs1_data/in_rs2_data;
//        out_valid/out_ready + out_aluop/out_operand_1/out_operand_2/out_rd/out_illegal.
interface alu_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluop;
  logic [31:0] out_operand_1;
  logic [31:0] out_operand_2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_aluop, out_operand_1, out_operand_2, out_rd, out_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_aluop, out_operand_1, out_operand_2, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU op + operands.
// Latency 1 cycle (registered output), throughput 1/cycle.
// Backpressure: 2-entry (main + skid) buffer; in_ready is registered as !skid_valid.
//
// Ports: clk, rst (async active-high); bus (alu_issue_if.slave) carries flush,
//        the upstream instruction handshake and the downstream ALU handshake.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        illegal;
  } rec_t;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  rec_t        dec;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];
  assign imm_i  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
  assign imm_u  = {bus.in_inst[31:12], 12'b0};
  assign shamt  = {27'b0, bus.in_inst[24:20]};

  always_comb begin
    dec = '0;
    dec.aluop = ALU_ADD;
    dec.rd    = bus.in_inst[11:7];
    case (opcode)
      OPC_OP: begin
        dec.op1 = bus.in_rs1_data;
        dec.op2 = bus.in_rs2_data;
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
        dec.illegal = (funct7 != F7_ZERO) &&
                      !((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
          3'b000:  dec.aluop = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  dec.aluop = ALU_SLL;
          3'b010:  dec.aluop = ALU_SLT;
          3'b011:  dec.aluop = ALU_SLTU;
          3'b100:  dec.aluop = ALU_XOR;
          3'b101:  dec.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.aluop = ALU_OR;
          default: dec.aluop = ALU_AND;
        endcase
      end
      OPC_OPIMM: begin
        dec.op1 = bus.in_rs1_data;
        dec.op2 = imm_i;
        case (funct3)
          3'b000: dec.aluop = ALU_ADD;
          3'b001: begin
            dec.aluop   = ALU_SLL;
            dec.op2     = shamt;
            dec.illegal = (funct7 != F7_ZERO);
          end
          3'b010: dec.aluop = ALU_SLT;
          3'b011: dec.aluop = ALU_SLTU;
          3'b100: dec.aluop = ALU_XOR;
          3'b101: begin
            dec.aluop   = funct7[5] ? ALU_SRA : ALU_SRL;
            dec.op2     = shamt;
            dec.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          end
          3'b110:  dec.aluop = ALU_OR;
          default: dec.aluop = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec.op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.op1 = bus.in_pc;
        dec.op2 = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal ops still issue, but as a harmless ADD 0+0 into x0.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------- main + skid
  rec_t main_q, main_d;
  rec_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;
  logic transfer;
  logic main_free;

  assign transfer  = bus.in_valid & in_ready_q;
  // Main can take a new record at this edge if it is empty or being drained.
  assign main_free = !out_valid_q | bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // in_ready_q is 0 here, so no transfer can collide with the refill.
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (transfer) begin
        main_d      = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (transfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_aluop     = main_q.aluop;
  assign bus.out_operand_1 = main_q.op1;
  assign bus.out_operand_2 = main_q.op2;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, skid stall/drain, flush, async reset.
// Inputs driven and outputs checked at the falling edge.
// Expected values are hand-computed from the instruction encodings.
module tb_alu_issue;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_issue_if bus ();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic ill);
    chk({tag, ".valid"},   {31'b0, bus.out_valid},   {31'b0, vld});
    chk({tag, ".aluop"},   {28'b0, bus.out_aluop},   {28'b0, op});
    chk({tag, ".op1"},     bus.out_operand_1,        a);
    chk({tag, ".op2"},     bus.out_operand_2,        b);
    chk({tag, ".rd"},      {27'b0, bus.out_rd},      {27'b0, rd});
    chk({tag, ".illegal"}, {31'b0, bus.out_illegal}, {31'b0, ill});
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid    = 1'b1;
    bus.in_inst     = inst;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_inst     = '0;
    bus.in_pc       = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // ---- decode vectors, streamed back to back with out_ready high
    bus.out_ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);            // ADD x3,x1,x2
    tick();
    check_out("add", 1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b0);
    drive(32'h40435293, 32'h0, 32'h100, 32'h0);          // SRAI x5,x6,4
    tick();
    check_out("srai", 1'b1, 4'b0111, 32'h100, 32'd4, 5'd5, 1'b0);
    drive(32'h40431293, 32'h0, 32'h100, 32'h0);          // SLLI with funct7=0100000
    tick();
    check_out("slli_bad", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1);
    drive(32'hFFF00093, 32'h0, 32'h0, 32'h0);            // ADDI x1,x0,-1
    tick();
    check_out("addi", 1'b1, 4'b0000, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0);
    drive(32'h12345117, 32'h1000, 32'h55, 32'h0);        // AUIPC x2,0x12345
    tick();
    check_out("auipc", 1'b1, 4'b0000, 32'h1000, 32'h12345000, 5'd2, 1'b0);
    drive(32'hABCDE237, 32'h40, 32'hDEAD, 32'h0);        // LUI x4,0xABCDE
    tick();
    check_out("lui", 1'b1, 4'b0000, 32'd0, 32'hABCDE000, 5'd4, 1'b0);
    drive(32'h409403B3, 32'h0, 32'd20, 32'd3);           // SUB x7,x8,x9
    tick();
    check_out("sub", 1'b1, 4'b0001, 32'd20, 32'd3, 5'd7, 1'b0);
    drive(32'h00C5B533, 32'h0, 32'd1, 32'd2);            // SLTU x10,x11,x12
    tick();
    check_out("sltu", 1'b1, 4'b1001, 32'd1, 32'd2, 5'd10, 1'b0);
    drive(32'h022081B3, 32'h0, 32'd5, 32'd7);            // MUL (funct7=0000001)
    tick();
    check_out("mul_bad", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1);
    drive(32'h00002183, 32'h0, 32'd5, 32'd7);            // LW opcode
    tick();
    check_out("load_bad", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("idle.valid", {31'b0, bus.out_valid}, 32'd0);

    // ---- skid: A issues, then stall while B and C are offered
    drive(32'h002081B3, 32'h0, 32'hA, 32'd1);            // A: ADD rd3
    tick();
    check_out("A", 1'b1, 4'b0000, 32'hA, 32'd1, 5'd3, 1'b0);
    bus.out_ready = 1'b0;
    drive(32'h409403B3, 32'h0, 32'hB, 32'd2);            // B: SUB rd7
    tick();
    check_out("A_hold1", 1'b1, 4'b0000, 32'hA, 32'd1, 5'd3, 1'b0);
    chk("skid.in_ready0", {31'b0, bus.in_ready}, 32'd0);
    drive(32'h00C5B533, 32'h0, 32'hC, 32'd3);            // C: SLTU rd10
    tick();
    check_out("A_hold2", 1'b1, 4'b0000, 32'hA, 32'd1, 5'd3, 1'b0);
    chk("skid.in_ready1", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check_out("B", 1'b1, 4'b0001, 32'hB, 32'd2, 5'd7, 1'b0);
    chk("drain.in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    check_out("C", 1'b1, 4'b1001, 32'hC, 32'd3, 5'd10, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("after_C.valid", {31'b0, bus.out_valid}, 32'd0);

    // ---- flush with main and skid full and a new instruction offered
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'hD, 32'd0);
    tick();
    drive(32'h002081B3, 32'h0, 32'hE, 32'd0);
    tick();
    chk("full.in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    drive(32'h002081B3, 32'h0, 32'hF, 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush.in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush.nothing_issues", {31'b0, bus.out_valid}, 32'd0);
    end

    // ---- flush beats a same-cycle transfer into an empty stage
    bus.flush = 1'b1;
    drive(32'h002081B3, 32'h0, 32'h77, 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_xfer.valid", {31'b0, bus.out_valid}, 32'd0);

    // ---- async reset mid-stall
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'h1, 32'd0);
    tick();
    drive(32'h002081B3, 32'h0, 32'h2, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("stall.valid", {31'b0, bus.out_valid}, 32'd1);
    chk("stall.in_ready", {31'b0, bus.in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst.in_ready", {31'b0, bus.in_ready}, 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(32'h00C5B533, 32'h0, 32'h33, 32'h44);          // SLTU x10,x11,x12
    tick();
    check_out("post_rst", 1'b1, 4'b1001, 32'h33, 32'h44, 5'd10, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("post_rst.drain", {31'b0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
